piso_serializer: RTL

PISO_SERIALIZER -- requirements
Module: piso_serializer

---
 rtl/piso_pkg.sv | 14 +
 rtl/piso_bit_counter.sv | 42 ++++
 rtl/piso_serializer.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/piso_pkg.sv
// Shared encodings for the PISO serializer: FSM state codes and the state enum.
package piso_pkg;

    localparam logic [1:0] ST_IDLE_ENC   = 2'd0;
    localparam logic [1:0] ST_SHIFT_ENC  = 2'd1;
    localparam logic [1:0] ST_PARITY_ENC = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE   = ST_IDLE_ENC,
        ST_SHIFT  = ST_SHIFT_ENC,
        ST_PARITY = ST_PARITY_ENC
    } piso_state_t;

endpackage

// File: rtl/piso_bit_counter.sv
// Wrapping bit counter 0..MAX_COUNT with synchronous clear (priority) and enable.
module piso_bit_counter #(
    parameter int              WIDTH     = 3,
    parameter logic [WIDTH-1:0] MAX_COUNT = {WIDTH{1'b1}}
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    logic [WIDTH-1:0] count_q, count_d;

    // Next count: clear wins over enable, wrap to zero after the terminal count.
    always_comb begin
        count_d = count_q;
        if (i_clr) begin
            count_d = {WIDTH{1'b0}};
        end else if (i_en) begin
            if (count_q == MAX_COUNT) begin
                count_d = {WIDTH{1'b0}};
            end else begin
                count_d = count_q + WIDTH'(1'b1);
            end
        end else begin
            count_d = count_q;
        end
    end

    // Counter register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count_q <= {WIDTH{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign o_tc = (count_q == MAX_COUNT);

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out serializer with ready/valid accept and zero-bubble reload.
// Optional trailing even-parity bit when PISO_PARITY_EN is defined.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int LENGTH    = 8,
    parameter int MSB_FIRST = 0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [LENGTH-1:0] i_data,
    input  logic              i_valid,
    output logic              o_ready,
    output logic              o_dout,
    output logic              o_dout_valid,
    output logic              o_last,
    output logic              o_busy
);

    localparam int              CNT_W   = $clog2(LENGTH);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LENGTH - 1);

    piso_state_t       state_q, state_d;
    logic [LENGTH-1:0] shift_q, shift_d;
    logic              rdy_en_q, rdy_en_d;
    logic              cnt_tc_s;
    logic              cnt_en_s;
    logic              accept_s;
    logic              last_s;
    logic              ready_s;
    logic              dout_s;

`ifdef PISO_PARITY_EN
    logic              par_q, par_d;

    function automatic logic calc_even_parity(input logic [LENGTH-1:0] word);
        return ^word;
    endfunction
`endif

    assign cnt_en_s = (state_q == ST_SHIFT);

    piso_bit_counter #(
        .WIDTH     (CNT_W),
        .MAX_COUNT (CNT_MAX)
    ) u_bit_counter (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (accept_s),
        .i_en    (cnt_en_s),
        .o_tc    (cnt_tc_s)
    );

    // Handshake and output decode; ready is held off until the first edge after reset.
    always_comb begin
`ifdef PISO_PARITY_EN
        last_s = (state_q == ST_PARITY);
`else
        last_s = (state_q == ST_SHIFT) && cnt_tc_s;
`endif
        ready_s  = rdy_en_q && ((state_q == ST_IDLE) || last_s);
        accept_s = i_valid && ready_s;
        case (state_q)
            ST_SHIFT: begin
                if (MSB_FIRST != 0) begin
                    dout_s = shift_q[LENGTH-1];
                end else begin
                    dout_s = shift_q[0];
                end
            end
`ifdef PISO_PARITY_EN
            ST_PARITY: dout_s = par_q;
`endif
            default:  dout_s = 1'b0;
        endcase
    end

    // Next-state, shift-register and parity computation.
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        rdy_en_d = 1'b1;
`ifdef PISO_PARITY_EN
        par_d    = par_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d = ST_SHIFT;
                    shift_d = i_data;
`ifdef PISO_PARITY_EN
                    par_d   = calc_even_parity(i_data);
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (MSB_FIRST != 0) begin
                    shift_d = {shift_q[LENGTH-2:0], 1'b0};
                end else begin
                    shift_d = {1'b0, shift_q[LENGTH-1:1]};
                end
                if (cnt_tc_s) begin
`ifdef PISO_PARITY_EN
                    state_d = ST_PARITY;
`else
                    // Reload on the final bit keeps the stream gap-free.
                    if (accept_s) begin
                        state_d = ST_SHIFT;
                        shift_d = i_data;
                    end else begin
                        state_d = ST_IDLE;
                    end
`endif
                end else begin
                    state_d = ST_SHIFT;
                end
            end
`ifdef PISO_PARITY_EN
            ST_PARITY: begin
                if (accept_s) begin
                    state_d = ST_SHIFT;
                    shift_d = i_data;
                    par_d   = calc_even_parity(i_data);
                end else begin
                    state_d = ST_IDLE;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
                shift_d = {LENGTH{1'b0}};
            end
        endcase
    end

    // State, data and ready-enable registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= ST_IDLE;
            shift_q  <= {LENGTH{1'b0}};
            rdy_en_q <= 1'b0;
`ifdef PISO_PARITY_EN
            par_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            rdy_en_q <= rdy_en_d;
`ifdef PISO_PARITY_EN
            par_q    <= par_d;
`endif
        end
    end

    assign o_ready      = ready_s;
    assign o_dout       = dout_s;
    assign o_dout_valid = (state_q != ST_IDLE);
    assign o_last       = last_s;
    assign o_busy       = (state_q != ST_IDLE);

endmodule
